// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler sharing one UART transmitter among NUM_REQ requesters,
// with CTS gating, start-handshake timeout and a saturating frame counter.
module uart_tx_arbiter #(
    parameter int unsigned NUM_REQ       = 4,
    parameter int unsigned DATA_BITS     = 8,
    parameter int unsigned START_TIMEOUT = 16,
    parameter int unsigned CNT_WIDTH     = 16
) (
    input  logic                           i_Clk,
    input  logic                           i_Rst,
    input  logic [NUM_REQ-1:0]             i_Req,
    input  logic [NUM_REQ*DATA_BITS-1:0]   i_Req_Data,
    input  logic                           i_CTS,
    input  logic                           i_Tx_Busy,
    output logic [NUM_REQ-1:0]             o_Grant,
    output logic [DATA_BITS-1:0]           o_Tx_Data,
    output logic                           o_Transmit_Start,
    output logic                           o_Frame_Done,
    output logic                           o_Start_Error,
    output logic                           o_Arb_Busy,
    output logic [CNT_WIDTH-1:0]           o_Frame_Count
);

    localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned TO_W  = $clog2(START_TIMEOUT);

    typedef enum logic [1:0] {StIdle, StStart, StWaitDone} state_t;

    state_t            r_state;
    logic [PTR_W-1:0]  r_ptr;
    logic [TO_W-1:0]   r_cnt;

    logic              w_found;
    logic [PTR_W-1:0]  w_winner;
    int unsigned       w_idx;

    // First requesting index after the last winner, wrapping modulo NUM_REQ.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_idx    = 0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            w_idx = (32'(r_ptr) + k) % NUM_REQ;
            if (!w_found && i_Req[w_idx[PTR_W-1:0]]) begin
                w_found  = 1'b1;
                w_winner = w_idx[PTR_W-1:0];
            end
        end
    end

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            r_state          <= StIdle;
            r_ptr            <= PTR_W'(NUM_REQ - 1);
            r_cnt            <= '0;
            o_Grant          <= '0;
            o_Tx_Data        <= '0;
            o_Transmit_Start <= 1'b0;
            o_Frame_Done     <= 1'b0;
            o_Start_Error    <= 1'b0;
            o_Arb_Busy       <= 1'b0;
            o_Frame_Count    <= '0;
        end else begin
            o_Grant       <= '0;
            o_Frame_Done  <= 1'b0;
            o_Start_Error <= 1'b0;
            case (r_state)
                StIdle: begin
                    if (i_CTS && !i_Tx_Busy && w_found) begin
                        r_state          <= StStart;
                        o_Arb_Busy       <= 1'b1;
                        o_Grant          <= NUM_REQ'(1) << w_winner;
                        o_Tx_Data        <= i_Req_Data[w_winner*DATA_BITS +: DATA_BITS];
                        o_Transmit_Start <= 1'b1;
                        r_cnt            <= '0;
                        r_ptr            <= w_winner;
                    end
                end
                StStart: begin
                    if (i_Tx_Busy) begin
                        o_Transmit_Start <= 1'b0;
                        r_state          <= StWaitDone;
                    end else if (r_cnt == TO_W'(START_TIMEOUT - 1)) begin
                        o_Transmit_Start <= 1'b0;
                        o_Start_Error    <= 1'b1;
                        o_Arb_Busy       <= 1'b0;
                        r_state          <= StIdle;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                StWaitDone: begin
                    if (!i_Tx_Busy) begin
                        o_Frame_Done <= 1'b1;
                        o_Arb_Busy   <= 1'b0;
                        r_state      <= StIdle;
                        if (o_Frame_Count != '1) begin
                            o_Frame_Count <= o_Frame_Count + 1'b1;
                        end
                    end
                end
                default: begin
                    r_state    <= StIdle;
                    o_Arb_Busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: directed scenarios plus randomized
// transactions checked against a transaction-level round-robin model.
module tb_uart_tx_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic        cts;
    logic        busy;
    logic [3:0]  grant;
    logic [7:0]  tx_data;
    logic        ts;
    logic        fd;
    logic        se;
    logic        arb_busy;
    logic [15:0] fcount;

    int checks = 0;
    int errors = 0;
    int m_last;
    int m_count;

    uart_tx_arbiter #(
        .NUM_REQ(4), .DATA_BITS(8), .START_TIMEOUT(16), .CNT_WIDTH(16)
    ) dut (
        .i_Clk(clk), .i_Rst(rst), .i_Req(req), .i_Req_Data(req_data), .i_CTS(cts),
        .i_Tx_Busy(busy), .o_Grant(grant), .o_Tx_Data(tx_data), .o_Transmit_Start(ts),
        .o_Frame_Done(fd), .o_Start_Error(se), .o_Arb_Busy(arb_busy),
        .o_Frame_Count(fcount)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Reference: first requester after the last winner, wrapping around.
    function automatic int exp_winner(input logic [3:0] r, input int last);
        for (int k = 1; k <= 4; k++) begin
            if (r[(last + k) % 4]) return (last + k) % 4;
        end
        return -1;
    endfunction

    function automatic logic [7:0] lane(input int i);
        return req_data[i*8 +: 8];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_grant(input int bound, output logic [3:0] g, output int waited);
        g = '0;
        waited = 0;
        while (waited < bound && g == 4'b0) begin
            step();
            waited++;
            g = grant;
        end
    endtask

    // UART model: busy rises dly cycles after the grant cycle and stays for len cycles.
    task automatic serve(input int dly, input int len, output bit ts_dropped,
                         output bit fd_seen);
        repeat (dly) step();
        busy = 1'b1;
        step();
        ts_dropped = (ts === 1'b0);
        repeat (len - 1) step();
        busy = 1'b0;
        fd_seen = 1'b0;
        for (int i = 0; i < 4 && !fd_seen; i++) begin
            step();
            if (fd === 1'b1) fd_seen = 1'b1;
        end
    endtask

    task automatic test_reset();
        logic [3:0] g; int w; bit tsd, fds; int ew;
        rst = 1'b1; req = '0; req_data = '0; cts = 1'b0; busy = 1'b0;
        step(); step();
        checks++;
        if ({grant, tx_data, ts, fd, se, arb_busy, fcount} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got g=%b d=%h ts=%b fd=%b se=%b ab=%b cnt=%0d required all 0",
                     grant, tx_data, ts, fd, se, arb_busy, fcount);
        end
        rst = 1'b0; m_last = 3; m_count = 0;
        req = 4'b1111; req_data = 32'hA3A2A1A0; cts = 1'b1;
        wait_grant(4, g, w);
        ew = exp_winner(4'b1111, m_last);
        checks++;
        if (g !== 4'(1 << ew) || w != 1) begin
            errors++;
            $display("FAIL reset_first_grant: got %b after %0d cycles required %b after 1",
                     g, w, 4'(1 << ew));
        end
        checks++;
        if (ts !== 1'b1 || arb_busy !== 1'b1) begin
            errors++;
            $display("FAIL reset_start_busy: got ts=%b ab=%b required 1 1", ts, arb_busy);
        end
        m_last = ew; req = '0;
        serve(2, 12, tsd, fds);
        m_count++;
        checks++;
        if (!fds || fcount !== 16'(m_count)) begin
            errors++;
            $display("FAIL reset_frame: got fd=%b cnt=%0d required 1 %0d", fds, fcount, m_count);
        end
    endtask

    task automatic test_round_robin();
        logic [3:0] g; int w; bit tsd, fds; int ew;
        rst = 1'b1; step(); step();
        rst = 1'b0; m_last = 3; m_count = 0;
        req_data = 32'h13121110; req = 4'b1111; cts = 1'b1;
        for (int t = 0; t < 5; t++) begin
            wait_grant(4, g, w);
            ew = exp_winner(req, m_last);
            checks++;
            if (g !== 4'(1 << ew)) begin
                errors++;
                $display("FAIL rr_grant[%0d]: got %b required %b", t, g, 4'(1 << ew));
            end
            checks++;
            if (tx_data !== lane(ew)) begin
                errors++;
                $display("FAIL rr_data[%0d]: got %h required %h", t, tx_data, lane(ew));
            end
            m_last = ew;
            serve(2, 12, tsd, fds);
            if (t == 4) req = '0;
            m_count++;
            checks++;
            if (!tsd || !fds) begin
                errors++;
                $display("FAIL rr_handshake[%0d]: got ts_drop=%b fd=%b required 1 1", t, tsd, fds);
            end
        end
        checks++;
        if (fcount !== 16'(m_count)) begin
            errors++;
            $display("FAIL rr_count: got %0d required %0d", fcount, m_count);
        end
    endtask

    task automatic test_flow_control();
        bit saw, tsd, fds; int ew;
        cts = 1'b0; req_data = $urandom; req = 4'b0100; saw = 1'b0;
        repeat (20) begin
            step();
            if (grant !== 4'b0) saw = 1'b1;
        end
        checks++;
        if (saw) begin
            errors++;
            $display("FAIL fc_blocked: got grant while CTS=0 required none");
        end
        cts = 1'b1;
        step();
        ew = exp_winner(4'b0100, m_last);
        checks++;
        if (grant !== 4'(1 << ew) || tx_data !== lane(ew)) begin
            errors++;
            $display("FAIL fc_grant: got %b/%h required %b/%h", grant, tx_data,
                     4'(1 << ew), lane(ew));
        end
        m_last = ew; req = '0; cts = 1'b0;
        serve(2, 6, tsd, fds);
        m_count++;
        checks++;
        if (!fds || fcount !== 16'(m_count)) begin
            errors++;
            $display("FAIL fc_complete: got fd=%b cnt=%0d required 1 %0d", fds, fcount, m_count);
        end
        cts = 1'b1;
    endtask

    task automatic test_timeout();
        logic [3:0] g; int w, hi, ew; bit tsd, fds;
        busy = 1'b0; req_data = $urandom; req = 4'b0010; cts = 1'b1;
        wait_grant(4, g, w);
        ew = exp_winner(4'b0010, m_last);
        checks++;
        if (g !== 4'(1 << ew)) begin
            errors++;
            $display("FAIL to_grant: got %b required %b", g, 4'(1 << ew));
        end
        m_last = ew; req = '0;
        hi = (ts === 1'b1) ? 1 : 0;
        for (int i = 0; i < 40 && ts === 1'b1; i++) begin
            step();
            if (ts === 1'b1) hi++;
        end
        checks++;
        if (hi != 16 || se !== 1'b1) begin
            errors++;
            $display("FAIL to_start_len: got ts_cycles=%0d se=%b required 16 1", hi, se);
        end
        step();
        checks++;
        if (se !== 1'b0 || fd !== 1'b0 || fcount !== 16'(m_count)) begin
            errors++;
            $display("FAIL to_after: got se=%b fd=%b cnt=%0d required 0 0 %0d",
                     se, fd, fcount, m_count);
        end
        req = 4'b0010;
        wait_grant(4, g, w);
        ew = exp_winner(4'b0010, m_last);
        checks++;
        if (g !== 4'(1 << ew)) begin
            errors++;
            $display("FAIL to_regrant: got %b required %b", g, 4'(1 << ew));
        end
        m_last = ew; req = '0;
        serve(1, 4, tsd, fds);
        m_count++;
        checks++;
        if (!fds || fcount !== 16'(m_count)) begin
            errors++;
            $display("FAIL to_recover: got fd=%b cnt=%0d required 1 %0d", fds, fcount, m_count);
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [3:0] g; int w, ew; bit fd_bad, tsd, fds;
        req = 4'b0001; cts = 1'b1;
        wait_grant(4, g, w);
        req = '0; busy = 1'b1;
        step(); step();
        rst = 1'b1;
        step();
        checks++;
        if (ts !== 1'b0 || fd !== 1'b0 || se !== 1'b0 || arb_busy !== 1'b0 || fcount !== 16'd0) begin
            errors++;
            $display("FAIL rmf_reset: got ts=%b fd=%b se=%b ab=%b cnt=%0d required all 0",
                     ts, fd, se, arb_busy, fcount);
        end
        rst = 1'b0; busy = 1'b0; m_last = 3; m_count = 0; req = 4'b1000;
        g = '0; fd_bad = 1'b0;
        for (int i = 0; i < 4 && g == 4'b0; i++) begin
            step();
            g = grant;
            if (fd === 1'b1) fd_bad = 1'b1;
        end
        ew = exp_winner(4'b1000, m_last);
        checks++;
        if (fd_bad || g !== 4'(1 << ew)) begin
            errors++;
            $display("FAIL rmf_next: got fd_pulse=%b grant=%b required 0 %b", fd_bad, g,
                     4'(1 << ew));
        end
        m_last = ew; req = '0;
        serve(0, 3, tsd, fds);
        m_count++;
        checks++;
        if (fcount !== 16'(m_count)) begin
            errors++;
            $display("FAIL rmf_count: got %0d required %0d", fcount, m_count);
        end
    endtask

    task automatic test_blocked_busy();
        bit saw, tsd, fds; int ew;
        busy = 1'b1; cts = 1'b1; req_data = $urandom; req = 4'b0101; saw = 1'b0;
        repeat (10) begin
            step();
            if (grant !== 4'b0) saw = 1'b1;
        end
        busy = 1'b0;
        step();
        ew = exp_winner(4'b0101, m_last);
        checks++;
        if (saw || grant !== 4'(1 << ew)) begin
            errors++;
            $display("FAIL busy_block: got early=%b grant=%b required 0 %b", saw, grant,
                     4'(1 << ew));
        end
        m_last = ew; req = '0;
        serve(1, 3, tsd, fds);
        m_count++;
    endtask

    task automatic test_random();
        logic [3:0] g, r; int w, ew, gap, hi; bit saw, tsd, fds; logic [7:0] latched;
        for (int t = 0; t < 40; t++) begin
            r = 4'($urandom_range(1, 15));
            req_data = $urandom; gap = $urandom_range(0, 3);
            cts = 1'b0; req = r; saw = 1'b0;
            repeat (gap) begin
                step();
                if (grant !== 4'b0) saw = 1'b1;
            end
            cts = 1'b1;
            wait_grant(3, g, w);
            ew = exp_winner(r, m_last);
            latched = lane(ew);
            checks++;
            if (saw || g !== 4'(1 << ew) || w != 1 || tx_data !== latched) begin
                errors++;
                $display("FAIL rnd_grant[%0d]: got early=%b g=%b lat=%0d d=%h required 0 %b 1 %h",
                         t, saw, g, w, tx_data, 4'(1 << ew), latched);
            end
            m_last = ew; req = '0; req_data = $urandom;
            if ($urandom_range(0, 4) == 0) begin
                hi = (ts === 1'b1) ? 1 : 0;
                for (int i = 0; i < 40 && ts === 1'b1; i++) begin
                    step();
                    if (ts === 1'b1) hi++;
                end
                checks++;
                if (hi != 16 || se !== 1'b1 || fcount !== 16'(m_count)) begin
                    errors++;
                    $display("FAIL rnd_timeout[%0d]: got cyc=%0d se=%b cnt=%0d required 16 1 %0d",
                             t, hi, se, fcount, m_count);
                end
                step();
            end else begin
                serve($urandom_range(0, 4), $urandom_range(1, 8), tsd, fds);
                m_count++;
                checks++;
                if (!tsd || !fds || fcount !== 16'(m_count) || tx_data !== latched) begin
                    errors++;
                    $display("FAIL rnd_frame[%0d]: got tsd=%b fd=%b cnt=%0d d=%h required 1 1 %0d %h",
                             t, tsd, fds, fcount, tx_data, m_count, latched);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_flow_control();
        test_timeout();
        test_reset_mid_frame();
        test_blocked_busy();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin transmit scheduler that shares the single UART transmitter among `NUM_REQ` on-chip requesters. It sits between the requesters and the UART's `Tx_Data`/`Transmit_Start`/`Tx_Busy` port and sequences one frame at a time. It honours `CTS` flow control and supervises the start handshake with a timeout. It also reports frame completion and keeps a running frame count.

## Interface
- `NUM_REQ`, 4: number of requesters (2..8).
- `DATA_BITS`, 8: UART data width; matches the UART instance.
- `START_TIMEOUT`, 16: cycles `Transmit_Start` may stay high without `Tx_Busy` rising (≥2).
- `CNT_WIDTH`, 16: width of the frame counter.

Ports:
- `Clk`  in  1  baud-domain clock; all logic on posedge.
- `Rst`  in  1  synchronous, active-high reset.
- `Req`  in  NUM_REQ  per-requester level request; held until granted.
- `Req_Data`  in  NUM_REQ*DATA_BITS  requester i's byte at bits [i*DATA_BITS +: DATA_BITS].
- `CTS`  in  1  1 = far end clear to send; gates new grants only.
- `Tx_Busy`  in  1  UART transmitter busy.
- `Grant`  out  NUM_REQ  one-hot, one-cycle pulse: requester's byte accepted.
- `Tx_Data`  out  DATA_BITS  registered byte to UART.
- `Transmit_Start`  out  1  start strobe to UART.
- `Frame_Done`  out  1  one-cycle pulse when a granted frame finishes.
- `Start_Error`  out  1  one-cycle pulse on start-handshake timeout.
- `Arb_Busy`  out  1  high in any state except IDLE.
- `Frame_Count`  out  CNT_WIDTH  completed frames, saturating at all-ones.

## Operation
- States: IDLE, START, WAIT_DONE. All outputs are registered.
- Round-robin pointer `Ptr` holds the last granted index.
  - Search starts at `Ptr+1` and wraps modulo `NUM_REQ`.
  - `Ptr` updates on every grant, including grants that later time out.
- IDLE → START when `CTS`=1, `Tx_Busy`=0 and `|Req`=1, all sampled at the same edge. At that edge:
  - `Tx_Data` ← winner's `Req_Data`.
  - `Grant[winner]` ← 1.
  - `Transmit_Start` ← 1.
  - Timeout counter ← 0.
  - `Ptr` ← winner.
- START: `Transmit_Start` is held at 1.
  - If `Tx_Busy`=1: `Transmit_Start` ← 0, go to WAIT_DONE.
  - Else, if counter = `START_TIMEOUT`-1: `Transmit_Start` ← 0, `Start_Error` pulses, go to IDLE. No `Frame_Done` and no count.
  - Else the counter increments.
- WAIT_DONE: when `Tx_Busy`=0, `Frame_Done` pulses, `Frame_Count` increments (saturating), go to IDLE.
- `CTS` falling during START or WAIT_DONE does not abort; it only blocks the next grant.
- `Tx_Busy` high while in IDLE (for example, BIST owns the transmitter) blocks grants.
- The requester may drop `Req` or change `Req_Data` in the cycle after its `Grant`. The byte is latched.
- `Req` dropped before being granted is simply not served. There is no memory of past requests.
- Reset values: state IDLE, `Ptr`=`NUM_REQ`-1 (requester 0 wins first), and all other outputs and `Frame_Count` = 0. This applies mid-frame too: `Transmit_Start` is 0 after the reset edge, and no `Frame_Done` or `Start_Error` is produced for the aborted frame.

## Timing
- Acceptance edge k: `Grant`, `Tx_Data` and `Transmit_Start` are valid in cycle k+1.
- `Grant` is high for exactly one cycle. `Tx_Data` is stable from k+1 until the next grant.
- `Tx_Busy` first sampled high at edge m: `Transmit_Start` is 0 from cycle m+1.
- `Tx_Busy` sampled low in WAIT_DONE at edge n: `Frame_Done` is high and `Frame_Count` is updated in cycle n+1. IDLE can grant again at edge n+1, so the earliest next `Grant` is cycle n+2.
- Timeout: if `Tx_Busy` never rises, `Transmit_Start` is high for exactly `START_TIMEOUT` cycles. `Start_Error` is high in the first cycle after that.
- `Arb_Busy` equals (state ≠ IDLE) and is registered together with the state.

## Test plan
- **Reset:** assert `Rst` 2 cycles → all outputs 0, `Arb_Busy`=0. Then `Req`=4'b1111, `CTS`=1 → first `Grant`=4'b0001.
- **Round robin:** all four requesters hold `Req` with data 8'h10..8'h13. Model the UART as busy for 12 cycles, rising 2 cycles after start.
  - `Grant` order is 0,1,2,3,0.
  - `Tx_Data` sequence is 10,11,12,13,10.
  - `Frame_Count`=5 after 5 `Frame_Done` pulses.
- **Flow control:** `CTS`=0 with `Req`=4'b0100 → no `Grant` for 20 cycles. Raise `CTS` → `Grant`=4'b0100 one cycle later. Drop `CTS` mid-frame → the frame completes and `Frame_Done` pulses.
- **Timeout:** `Tx_Busy` tied 0, `Req`=4'b0010 →
  - `Transmit_Start` high 16 cycles.
  - `Start_Error` pulses once, `Frame_Count` unchanged.
  - The next grant goes to requester 1 again only if it is the sole requester.
- **Reset mid-frame:** assert `Rst` during WAIT_DONE → no `Frame_Done`, `Frame_Count`=0, `Transmit_Start`=0. With `Req`=4'b1000, the next grant after release is requester 3.
- **Blocked by busy:** `Tx_Busy`=1 in IDLE for 10 cycles with `Req` pending → no `Grant` until one cycle after `Tx_Busy` is sampled low.
